// File: rtl/adder_pkg.sv
// Shared types and constants for the vector-add sequencer.
package adder_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        RD_A_REQ,
        RD_A_DATA,
        RD_B_REQ,
        RD_B_DATA,
        WR_REQ,
        WR_DATA,
        DONE
    } state_t;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    // Elements are 4-byte words, so element index becomes a byte offset by shifting.
    localparam int ELEM_BYTES_LOG2 = 2;

endpackage

// File: rtl/adder_cycle_counter.sv
// Saturating cycle counter with synchronous clear; exposes the value it will hold
// after the current cycle so the sequencer can report a count that includes it.
module adder_cycle_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] next_count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count;

    always_comb begin
        next_count = (&count) ? count : count + ONE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= next_count;
        end
    end

endmodule

// File: rtl/adder_ctrl.sv
// Vector-add sequencer: reads a[i] and b[i], writes c[i] = a[i] + b[i] one element at a
// time, then pulses finish and reports the number of cycles the run took.
module adder_ctrl
    import adder_pkg::*;
#(
    parameter int HOST_DATA_BITS = 32,
    parameter int MEM_ADDR_BITS  = 64,
    parameter int ELEM_BITS      = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      launch,
    output logic                      finish,
    output logic                      event_counter_valid,
    output logic [HOST_DATA_BITS-1:0] event_counter_value,
    input  logic [HOST_DATA_BITS-1:0] length,
    input  logic [HOST_DATA_BITS-1:0] a_addr,
    input  logic [HOST_DATA_BITS-1:0] b_addr,
    input  logic [HOST_DATA_BITS-1:0] c_addr,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_opcode,
    output logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
    output logic                      mem_wr_valid,
    input  logic                      mem_wr_ready,
    output logic [ELEM_BITS-1:0]      mem_wr_bits,
    input  logic                      mem_rd_valid,
    input  logic [ELEM_BITS-1:0]      mem_rd_bits,
    output logic                      mem_rd_deq
);

    localparam logic [HOST_DATA_BITS-1:0] IDX_ONE = {{(HOST_DATA_BITS-1){1'b0}}, 1'b1};

    state_t                    state;
    logic [HOST_DATA_BITS-1:0] length_r;
    logic [HOST_DATA_BITS-1:0] a_base;
    logic [HOST_DATA_BITS-1:0] b_base;
    logic [HOST_DATA_BITS-1:0] c_base;
    logic [HOST_DATA_BITS-1:0] idx;
    logic [ELEM_BITS-1:0]      a_r;
    logic [ELEM_BITS-1:0]      b_r;
    logic                      launch_armed;
    logic                      start;
    logic [HOST_DATA_BITS-1:0] cycles_next;

    function automatic logic [MEM_ADDR_BITS-1:0] elem_addr(
        input logic [HOST_DATA_BITS-1:0] base,
        input logic [HOST_DATA_BITS-1:0] index
    );
        return MEM_ADDR_BITS'(base) + (MEM_ADDR_BITS'(index) << ELEM_BYTES_LOG2);
    endfunction

    // A launch level left high after a run must be seen low before it can start another.
    assign start = (state == IDLE) && launch && launch_armed;

    assign mem_rd_deq = mem_rd_valid && ((state == RD_A_DATA) || (state == RD_B_DATA));

    adder_cycle_counter #(
        .WIDTH(HOST_DATA_BITS)
    ) u_cycle_counter (
        .clock     (clock),
        .reset     (reset),
        .clear     (start),
        .enable    (state != IDLE),
        .next_count(cycles_next)
    );

    // Request/write outputs are set on the transition into the state that owns them and
    // cleared only on their handshake, so they never change while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            length_r            <= '0;
            a_base              <= '0;
            b_base              <= '0;
            c_base              <= '0;
            idx                 <= '0;
            a_r                 <= '0;
            b_r                 <= '0;
            launch_armed        <= 1'b1;
            finish              <= 1'b0;
            event_counter_valid <= 1'b0;
            event_counter_value <= '0;
            mem_req_valid       <= 1'b0;
            mem_req_opcode      <= MEM_RD;
            mem_req_addr        <= '0;
            mem_wr_valid        <= 1'b0;
            mem_wr_bits         <= '0;
        end else begin
            finish              <= 1'b0;
            event_counter_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        length_r     <= length;
                        a_base       <= a_addr;
                        b_base       <= b_addr;
                        c_base       <= c_addr;
                        idx          <= '0;
                        launch_armed <= 1'b0;
                        state        <= CHECK;
                    end else if (!launch) begin
                        launch_armed <= 1'b1;
                    end
                end
                CHECK: begin
                    if (idx == length_r) begin
                        state <= DONE;
                    end else begin
                        mem_req_valid  <= 1'b1;
                        mem_req_opcode <= MEM_RD;
                        mem_req_addr   <= elem_addr(a_base, idx);
                        state          <= RD_A_REQ;
                    end
                end
                RD_A_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_req_addr  <= '0;
                        state         <= RD_A_DATA;
                    end
                end
                RD_A_DATA: begin
                    if (mem_rd_valid) begin
                        a_r            <= mem_rd_bits;
                        mem_req_valid  <= 1'b1;
                        mem_req_opcode <= MEM_RD;
                        mem_req_addr   <= elem_addr(b_base, idx);
                        state          <= RD_B_REQ;
                    end
                end
                RD_B_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_req_addr  <= '0;
                        state         <= RD_B_DATA;
                    end
                end
                RD_B_DATA: begin
                    if (mem_rd_valid) begin
                        b_r            <= mem_rd_bits;
                        mem_req_valid  <= 1'b1;
                        mem_req_opcode <= MEM_WR;
                        mem_req_addr   <= elem_addr(c_base, idx);
                        state          <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid  <= 1'b0;
                        mem_req_opcode <= MEM_RD;
                        mem_req_addr   <= '0;
                        mem_wr_valid   <= 1'b1;
                        mem_wr_bits    <= a_r + b_r;
                        state          <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (mem_wr_ready) begin
                        mem_wr_valid <= 1'b0;
                        mem_wr_bits  <= '0;
                        idx          <= idx + IDX_ONE;
                        state        <= CHECK;
                    end
                end
                DONE: begin
                    finish              <= 1'b1;
                    event_counter_valid <= 1'b1;
                    event_counter_value <= cycles_next;
                    state               <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_ctrl.sv
// Self-checking bench for adder_ctrl: a behavioural memory with optional stalls and read
// latency, a write scoreboard, and one task per scenario.
module tb_adder_ctrl;
    import adder_pkg::*;

    logic        clock;
    logic        reset;
    logic        launch;
    logic        finish;
    logic        event_counter_valid;
    logic [31:0] event_counter_value;
    logic [31:0] length;
    logic [31:0] a_addr;
    logic [31:0] b_addr;
    logic [31:0] c_addr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_opcode;
    logic [63:0] mem_req_addr;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic [31:0] mem_wr_bits;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_bits;
    logic        mem_rd_deq;

    adder_ctrl dut (
        .clock              (clock),
        .reset              (reset),
        .launch             (launch),
        .finish             (finish),
        .event_counter_valid(event_counter_valid),
        .event_counter_value(event_counter_value),
        .length             (length),
        .a_addr             (a_addr),
        .b_addr             (b_addr),
        .c_addr             (c_addr),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_opcode     (mem_req_opcode),
        .mem_req_addr       (mem_req_addr),
        .mem_wr_valid       (mem_wr_valid),
        .mem_wr_ready       (mem_wr_ready),
        .mem_wr_bits        (mem_wr_bits),
        .mem_rd_valid       (mem_rd_valid),
        .mem_rd_bits        (mem_rd_bits),
        .mem_rd_deq         (mem_rd_deq)
    );

    logic [31:0] mem [logic [63:0]];
    logic [63:0] wr_addr_q [$];
    logic [63:0] obs_addr_q [$];
    logic [31:0] obs_data_q [$];
    logic [63:0] exp_addr_q [$];
    logic [31:0] exp_data_q [$];
    logic [31:0] va [16];
    logic [31:0] vb [16];

    bit          stall_mode = 0;
    bit          rand_lat = 0;
    int          fixed_lat = 0;
    bit          rd_pending = 0;
    int          rd_delay = 0;
    logic [31:0] rd_data = '0;
    bit          rd_drop = 0;
    bit          req_stalled = 0;
    bit          wr_stalled = 0;
    logic [63:0] stall_addr = '0;
    logic        stall_op = 1'b0;
    logic [31:0] stall_bits = '0;
    int          stall_cycles = 0;
    int          stall_violations = 0;
    int          finish_count = 0;
    int          ecv_count = 0;
    int          pulse_mismatch = 0;
    int          req_valid_cycles = 0;
    int          rd_req_count = 0;
    int          cyc = 0;
    int          finish_cyc = 0;
    logic [31:0] ecv_value = '0;
    int          n_checks = 0;
    int          n_pass = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc = cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not end, got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Memory model: drive inputs at negedge, then (#1 later) look at what the next posedge will see.
    initial begin
        mem_req_ready = 1'b0;
        mem_wr_ready  = 1'b0;
        mem_rd_valid  = 1'b0;
        mem_rd_bits   = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                mem_rd_valid = 1'b0;
                mem_rd_bits  = '0;
                rd_pending   = 0;
                rd_drop      = 0;
                req_stalled  = 0;
                wr_stalled   = 0;
                wr_addr_q.delete();
            end else begin
                if (rd_drop) begin
                    mem_rd_valid = 1'b0;
                    mem_rd_bits  = '0;
                    rd_drop      = 0;
                end
                if (rd_pending) begin
                    if (rd_delay == 0) begin
                        mem_rd_valid = 1'b1;
                        mem_rd_bits  = rd_data;
                        rd_pending   = 0;
                    end else begin
                        rd_delay = rd_delay - 1;
                    end
                end
            end
            mem_req_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            mem_wr_ready  = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (!reset) begin
                if (req_stalled && (!mem_req_valid || mem_req_addr !== stall_addr || mem_req_opcode !== stall_op))
                    stall_violations++;
                if (wr_stalled && (!mem_wr_valid || mem_wr_bits !== stall_bits))
                    stall_violations++;
                req_stalled = mem_req_valid && !mem_req_ready;
                wr_stalled  = mem_wr_valid && !mem_wr_ready;
                if (req_stalled) begin
                    stall_addr = mem_req_addr;
                    stall_op   = mem_req_opcode;
                    stall_cycles++;
                end
                if (wr_stalled) begin
                    stall_bits = mem_wr_bits;
                    stall_cycles++;
                end
                if (mem_rd_valid && mem_rd_deq) rd_drop = 1;
                if (mem_req_valid) req_valid_cycles++;
                if (mem_req_valid && mem_req_ready) begin
                    if (mem_req_opcode == MEM_RD) begin
                        rd_pending = 1;
                        rd_delay   = rand_lat ? int'($urandom_range(0, 5)) : fixed_lat;
                        rd_data    = mem.exists(mem_req_addr) ? mem[mem_req_addr] : 32'h0;
                        rd_req_count++;
                    end else begin
                        wr_addr_q.push_back(mem_req_addr);
                    end
                end
                if (mem_wr_valid && mem_wr_ready) begin
                    if (wr_addr_q.size() > 0) obs_addr_q.push_back(wr_addr_q.pop_front());
                    else obs_addr_q.push_back(64'hDEAD_DEAD_DEAD_DEAD);
                    obs_data_q.push_back(mem_wr_bits);
                end
                if (finish) begin
                    finish_count++;
                    finish_cyc = cyc;
                end
                if (event_counter_valid) begin
                    ecv_count++;
                    ecv_value = event_counter_value;
                end
                if (finish !== event_counter_valid) pulse_mismatch++;
            end
        end
    end

    // Load vectors into memory and push the first n_exp expected writes to the scoreboard.
    task automatic applyStimulus(input int n, input int n_exp, input logic [31:0] ab,
                                 input logic [31:0] bb, input logic [31:0] cb);
        logic [31:0] s;
        obs_addr_q.delete();
        obs_data_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
        for (int i = 0; i < n; i++) begin
            mem[64'(ab) + 64'(i) * 64'd4] = va[i];
            mem[64'(bb) + 64'(i) * 64'd4] = vb[i];
            if (i < n_exp) begin
                s = va[i] + vb[i];
                exp_addr_q.push_back(64'(cb) + 64'(i) * 64'd4);
                exp_data_q.push_back(s);
            end
        end
        @(negedge clock);
        length = n;
        a_addr = ab;
        b_addr = bb;
        c_addr = cb;
    endtask

    task automatic start_run(output int acc);
        @(negedge clock);
        launch = 1'b1;
        @(posedge clock);
        #1 acc = cyc;
    endtask

    task automatic wait_finish(input int fc0, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            #2;
            if (finish_count > fc0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_checks++; if (finish !== 1'b0) $display("[TB] FAIL reset_finish: got %b expected 0", finish); else n_pass++;
        n_checks++; if (event_counter_valid !== 1'b0) $display("[TB] FAIL reset_ecv: got %b expected 0", event_counter_valid); else n_pass++;
        n_checks++; if (event_counter_value !== 32'h0) $display("[TB] FAIL reset_ecvalue: got %h expected 0", event_counter_value); else n_pass++;
        n_checks++; if (mem_req_valid !== 1'b0) $display("[TB] FAIL reset_req_valid: got %b expected 0", mem_req_valid); else n_pass++;
        n_checks++; if (mem_req_addr !== 64'h0) $display("[TB] FAIL reset_req_addr: got %h expected 0", mem_req_addr); else n_pass++;
        n_checks++; if (mem_wr_valid !== 1'b0) $display("[TB] FAIL reset_wr_valid: got %b expected 0", mem_wr_valid); else n_pass++;
        n_checks++; if (mem_wr_bits !== 32'h0) $display("[TB] FAIL reset_wr_bits: got %h expected 0", mem_wr_bits); else n_pass++;
    endtask

    task automatic test_basic();
        int acc, fc0, ec0;
        bit ok;
        logic [63:0] oa;
        logic [31:0] od;
        va[0] = 1;  va[1] = 2;  va[2] = 3;  va[3] = 4;
        vb[0] = 10; vb[1] = 20; vb[2] = 30; vb[3] = 40;
        applyStimulus(4, 4, 32'h100, 32'h200, 32'h300);
        fc0 = finish_count;
        ec0 = ecv_count;
        start_run(acc);
        @(negedge clock);
        launch = 1'b0;
        wait_finish(fc0, 500, ok);
        if (!ok) begin n_checks++; $display("[TB] FAIL basic_timeout: got no finish expected finish"); end
        repeat (5) @(negedge clock);
        #2;
        n_checks++; if (finish_count - fc0 !== 1) $display("[TB] FAIL basic_finish_pulses: got %0d expected 1", finish_count - fc0); else n_pass++;
        n_checks++; if (ecv_count - ec0 !== 1) $display("[TB] FAIL basic_ecv_pulses: got %0d expected 1", ecv_count - ec0); else n_pass++;
        n_checks++; if (pulse_mismatch !== 0) $display("[TB] FAIL basic_pulse_align: got %0d expected 0", pulse_mismatch); else n_pass++;
        n_checks++; if (ecv_value !== 32'd30) $display("[TB] FAIL basic_counter: got %0d expected 30", ecv_value); else n_pass++;
        n_checks++; if (finish_cyc - acc !== 30) $display("[TB] FAIL basic_latency: got %0d expected 30", finish_cyc - acc); else n_pass++;
        n_checks++; if (obs_addr_q.size() !== 4) $display("[TB] FAIL basic_write_count: got %0d expected 4", obs_addr_q.size()); else n_pass++;
        while (exp_addr_q.size() > 0) begin
            oa = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
            od = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : 'x;
            n_checks++; if (oa !== exp_addr_q[0]) $display("[TB] FAIL basic_addr: got %h expected %h", oa, exp_addr_q[0]); else n_pass++;
            n_checks++; if (od !== exp_data_q[0]) $display("[TB] FAIL basic_data: got %h expected %h", od, exp_data_q[0]); else n_pass++;
            void'(exp_addr_q.pop_front());
            void'(exp_data_q.pop_front());
        end
    endtask

    task automatic test_zero_length();
        int acc, fc0, rq0;
        bit ok;
        applyStimulus(0, 0, 32'h100, 32'h200, 32'h300);
        fc0 = finish_count;
        rq0 = req_valid_cycles;
        start_run(acc);
        @(negedge clock);
        launch = 1'b0;
        wait_finish(fc0, 100, ok);
        if (!ok) begin n_checks++; $display("[TB] FAIL zero_timeout: got no finish expected finish"); end
        repeat (3) @(negedge clock);
        #2;
        n_checks++; if (req_valid_cycles - rq0 !== 0) $display("[TB] FAIL zero_no_requests: got %0d expected 0", req_valid_cycles - rq0); else n_pass++;
        n_checks++; if (finish_cyc - acc !== 2) $display("[TB] FAIL zero_latency: got %0d expected 2", finish_cyc - acc); else n_pass++;
        n_checks++; if (ecv_value !== 32'd2) $display("[TB] FAIL zero_counter: got %0d expected 2", ecv_value); else n_pass++;
        n_checks++; if (finish_count - fc0 !== 1) $display("[TB] FAIL zero_finish_pulses: got %0d expected 1", finish_count - fc0); else n_pass++;
    endtask

    task automatic test_wrap();
        int acc, fc0;
        bit ok;
        logic [63:0] oa;
        logic [31:0] od;
        va[0] = 32'hFFFF_FFFF; va[1] = 32'd7;
        vb[0] = 32'd1;         vb[1] = 32'd8;
        applyStimulus(2, 2, 32'h1000, 32'h2000, 32'hFFFF_FFFC);
        fc0 = finish_count;
        start_run(acc);
        @(negedge clock);
        launch = 1'b0;
        wait_finish(fc0, 300, ok);
        if (!ok) begin n_checks++; $display("[TB] FAIL wrap_timeout: got no finish expected finish"); end
        repeat (3) @(negedge clock);
        #2;
        n_checks++; if (ecv_value !== 32'd16) $display("[TB] FAIL wrap_counter: got %0d expected 16", ecv_value); else n_pass++;
        n_checks++; if (obs_addr_q.size() !== 2) $display("[TB] FAIL wrap_write_count: got %0d expected 2", obs_addr_q.size()); else n_pass++;
        while (exp_addr_q.size() > 0) begin
            oa = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
            od = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : 'x;
            n_checks++; if (oa !== exp_addr_q[0]) $display("[TB] FAIL wrap_addr: got %h expected %h", oa, exp_addr_q[0]); else n_pass++;
            n_checks++; if (od !== exp_data_q[0]) $display("[TB] FAIL wrap_data: got %h expected %h", od, exp_data_q[0]); else n_pass++;
            void'(exp_addr_q.pop_front());
            void'(exp_data_q.pop_front());
        end
    endtask

    task automatic test_random_stalls();
        int acc, fc0, sv0, sc0;
        bit ok;
        logic [63:0] oa;
        logic [31:0] od;
        for (int i = 0; i < 8; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
        end
        applyStimulus(8, 8, 32'h4000, 32'h5000, 32'h6000);
        stall_mode = 1;
        rand_lat = 1;
        fc0 = finish_count;
        sv0 = stall_violations;
        sc0 = stall_cycles;
        start_run(acc);
        @(negedge clock);
        launch = 1'b0;
        wait_finish(fc0, 2000, ok);
        if (!ok) begin n_checks++; $display("[TB] FAIL stall_timeout: got no finish expected finish"); end
        stall_mode = 0;
        rand_lat = 0;
        repeat (3) @(negedge clock);
        #2;
        n_checks++; if (stall_violations - sv0 !== 0) $display("[TB] FAIL stall_stability: got %0d expected 0", stall_violations - sv0); else n_pass++;
        n_checks++; if ((stall_cycles - sc0 > 0) !== 1'b1) $display("[TB] FAIL stall_exercised: got %0d expected >0", stall_cycles - sc0); else n_pass++;
        n_checks++; if (ecv_value !== 32'(finish_cyc - acc)) $display("[TB] FAIL stall_counter: got %0d expected %0d", ecv_value, finish_cyc - acc); else n_pass++;
        n_checks++; if (obs_addr_q.size() !== 8) $display("[TB] FAIL stall_write_count: got %0d expected 8", obs_addr_q.size()); else n_pass++;
        while (exp_addr_q.size() > 0) begin
            oa = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
            od = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : 'x;
            n_checks++; if (oa !== exp_addr_q[0]) $display("[TB] FAIL stall_addr: got %h expected %h", oa, exp_addr_q[0]); else n_pass++;
            n_checks++; if (od !== exp_data_q[0]) $display("[TB] FAIL stall_data: got %h expected %h", od, exp_data_q[0]); else n_pass++;
            void'(exp_addr_q.pop_front());
            void'(exp_data_q.pop_front());
        end
    endtask

    task automatic test_reset_mid_run();
        int acc, fc0, rr0;
        bit ok;
        logic [63:0] oa;
        logic [31:0] od;
        for (int i = 0; i < 4; i++) begin
            va[i] = 32'h100 + i;
            vb[i] = 32'h200 + i;
        end
        applyStimulus(4, 2, 32'h700, 32'h800, 32'h900);
        fixed_lat = 3;
        fc0 = finish_count;
        rr0 = rd_req_count;
        start_run(acc);
        @(negedge clock);
        launch = 1'b0;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (rd_req_count - rr0 >= 6) begin
                ok = 1;
                break;
            end
            @(negedge clock);
            #2;
        end
        if (!ok) begin n_checks++; $display("[TB] FAIL abort_reach_rd_b: got %0d reads expected 6", rd_req_count - rr0); end
        @(posedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        #2;
        n_checks++; if (mem_req_valid !== 1'b0) $display("[TB] FAIL abort_req_valid: got %b expected 0", mem_req_valid); else n_pass++;
        n_checks++; if (mem_req_addr !== 64'h0) $display("[TB] FAIL abort_req_addr: got %h expected 0", mem_req_addr); else n_pass++;
        n_checks++; if (mem_rd_deq !== 1'b0) $display("[TB] FAIL abort_rd_deq: got %b expected 0", mem_rd_deq); else n_pass++;
        n_checks++; if (event_counter_value !== 32'h0) $display("[TB] FAIL abort_ecvalue: got %h expected 0", event_counter_value); else n_pass++;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        fixed_lat = 0;
        repeat (20) @(negedge clock);
        #2;
        n_checks++; if (finish_count - fc0 !== 0) $display("[TB] FAIL abort_no_finish: got %0d expected 0", finish_count - fc0); else n_pass++;
        n_checks++; if (obs_addr_q.size() !== 2) $display("[TB] FAIL abort_write_count: got %0d expected 2", obs_addr_q.size()); else n_pass++;
        while (exp_addr_q.size() > 0) begin
            oa = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
            od = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : 'x;
            n_checks++; if (oa !== exp_addr_q[0]) $display("[TB] FAIL abort_addr: got %h expected %h", oa, exp_addr_q[0]); else n_pass++;
            n_checks++; if (od !== exp_data_q[0]) $display("[TB] FAIL abort_data: got %h expected %h", od, exp_data_q[0]); else n_pass++;
            void'(exp_addr_q.pop_front());
            void'(exp_data_q.pop_front());
        end
        va[0] = 32'h5; va[1] = 32'h6;
        vb[0] = 32'h50; vb[1] = 32'h60;
        applyStimulus(2, 2, 32'hA00, 32'hB00, 32'hC00);
        fc0 = finish_count;
        start_run(acc);
        @(negedge clock);
        launch = 1'b0;
        wait_finish(fc0, 300, ok);
        if (!ok) begin n_checks++; $display("[TB] FAIL relaunch_timeout: got no finish expected finish"); end
        repeat (3) @(negedge clock);
        #2;
        n_checks++; if (ecv_value !== 32'd16) $display("[TB] FAIL relaunch_counter: got %0d expected 16", ecv_value); else n_pass++;
        n_checks++; if (obs_addr_q.size() !== 2) $display("[TB] FAIL relaunch_write_count: got %0d expected 2", obs_addr_q.size()); else n_pass++;
        while (exp_addr_q.size() > 0) begin
            oa = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
            od = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : 'x;
            n_checks++; if (oa !== exp_addr_q[0]) $display("[TB] FAIL relaunch_addr: got %h expected %h", oa, exp_addr_q[0]); else n_pass++;
            n_checks++; if (od !== exp_data_q[0]) $display("[TB] FAIL relaunch_data: got %h expected %h", od, exp_data_q[0]); else n_pass++;
            void'(exp_addr_q.pop_front());
            void'(exp_data_q.pop_front());
        end
    endtask

    task automatic test_csr_change();
        int acc, fc0;
        bit ok;
        logic [63:0] oa;
        logic [31:0] od;
        for (int i = 0; i < 3; i++) begin
            va[i] = 32'h1000 * (i + 1);
            vb[i] = 32'h0001 * (i + 3);
        end
        applyStimulus(3, 3, 32'h1100, 32'h1200, 32'h1300);
        fc0 = finish_count;
        start_run(acc);
        repeat (10) @(negedge clock);
        length = 32'd1;
        a_addr = 32'h9900;
        c_addr = 32'h0;
        wait_finish(fc0, 500, ok);
        if (!ok) begin n_checks++; $display("[TB] FAIL csr_timeout: got no finish expected finish"); end
        repeat (30) @(negedge clock);
        #2;
        n_checks++; if (finish_count - fc0 !== 1) $display("[TB] FAIL csr_single_finish: got %0d expected 1", finish_count - fc0); else n_pass++;
        n_checks++; if (ecv_value !== 32'd23) $display("[TB] FAIL csr_counter: got %0d expected 23", ecv_value); else n_pass++;
        n_checks++; if (obs_addr_q.size() !== 3) $display("[TB] FAIL csr_write_count: got %0d expected 3", obs_addr_q.size()); else n_pass++;
        while (exp_addr_q.size() > 0) begin
            oa = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
            od = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : 'x;
            n_checks++; if (oa !== exp_addr_q[0]) $display("[TB] FAIL csr_addr: got %h expected %h", oa, exp_addr_q[0]); else n_pass++;
            n_checks++; if (od !== exp_data_q[0]) $display("[TB] FAIL csr_data: got %h expected %h", od, exp_data_q[0]); else n_pass++;
            void'(exp_addr_q.pop_front());
            void'(exp_data_q.pop_front());
        end
        launch = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        reset  = 1'b1;
        launch = 1'b0;
        length = '0;
        a_addr = '0;
        b_addr = '0;
        c_addr = '0;
        repeat (3) @(negedge clock);
        #2;
        test_reset();
        reset = 1'b0;
        @(negedge clock);
        #2;
        test_reset();
        $display("[TB] basic run");
        test_basic();
        $display("[TB] zero length");
        test_zero_length();
        $display("[TB] sum and address wrap");
        test_wrap();
        $display("[TB] random stalls");
        test_random_stalls();
        $display("[TB] reset mid run");
        test_reset_mid_run();
        $display("[TB] csr change and held launch");
        test_csr_change();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
